// File: rtl/sub_32_bit_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
// Optional add mode is enabled by defining SUB32_ADD_MODE_EN.
package sub_serial_pkg;
   localparam int WIDTH_DEF   = 32;
   localparam int DIGIT_W_DEF = 4;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic int ndig(input int width, input int digit_w);
      return width / digit_w;
   endfunction

   // Counter only needs to index digits 0..NDIG-1; keep at least one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/sub_32_bit_serial_if.sv
// Operand/result handshake bundle for sub_32_bit_serial.
// op_add exists only when SUB32_ADD_MODE_EN is defined.
interface sub_32_bit_serial_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
`ifdef SUB32_ADD_MODE_EN
   logic             op_add;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   logic             zero;

`ifdef SUB32_ADD_MODE_EN
   modport master (output in_valid, a, b, bin, op_add, out_ready,
                   input  in_ready, out_valid, diff, bout, ovf, zero);
   modport slave  (input  in_valid, a, b, bin, op_add, out_ready,
                   output in_ready, out_valid, diff, bout, ovf, zero);
`else
   modport master (output in_valid, a, b, bin, out_ready,
                   input  in_ready, out_valid, diff, bout, ovf, zero);
   modport slave  (input  in_valid, a, b, bin, out_ready,
                   output in_ready, out_valid, diff, bout, ovf, zero);
`endif
endinterface

// File: rtl/sub_32_bit_serial_digit_sub.sv
// Combinational W-bit digit subtract with borrow in/out.
// With SUB32_ADD_MODE_EN, add=1 turns it into an adder (bi/bo act as carry).
module digit_sub #(parameter int W = 4) (
`ifdef SUB32_ADD_MODE_EN
   input  logic         add,
`endif
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bi,
   output logic [W-1:0] d,
   output logic         bo
);
   logic [W:0] sub_r;
   // Extra top bit goes to 1 exactly when the digit result is negative.
   assign sub_r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
`ifdef SUB32_ADD_MODE_EN
   logic [W:0] add_r;
   assign add_r   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, bi};
   assign {bo, d} = add ? add_r : sub_r;
`else
   assign {bo, d} = sub_r;
`endif
endmodule

// File: rtl/sub_32_bit_serial.sv
// Digit-serial WIDTH-bit subtractor: diff = a - b - bin, DIGIT_W bits per clock.
// Define SUB32_ADD_MODE_EN to add the op_add (a + b + bin) mode.
module sub_32_bit_serial
   import sub_serial_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int DIGIT_W = DIGIT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sub_32_bit_serial_if.slave   bus
);
   localparam int NDIG = ndig(WIDTH, DIGIT_W);
   localparam int CW   = cnt_w(NDIG);

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr, b_sr, diff_r, diff_nx;
   logic             brw, a_msb, b_msb;
   logic             bout_r, ovf_r, zero_r, ovld_r, ovf_nx;
   logic [DIGIT_W-1:0] dg;
   logic             dg_bo, accept, take, last;

   assign accept  = bus.in_valid && (state == IDLE);
   assign take    = ovld_r && bus.out_ready;
   assign last    = (cnt == CW'(NDIG - 1));
   assign diff_nx = {dg, diff_r[WIDTH-1:DIGIT_W]};

`ifdef SUB32_ADD_MODE_EN
   logic add_r;
   digit_sub #(.W(DIGIT_W)) u_dig (
      .add(add_r), .a(a_sr[DIGIT_W-1:0]), .b(b_sr[DIGIT_W-1:0]),
      .bi(brw), .d(dg), .bo(dg_bo));
   assign ovf_nx = add_r ? (~(a_msb ^ b_msb) & (diff_nx[WIDTH-1] ^ a_msb))
                         : ( (a_msb ^ b_msb) & (diff_nx[WIDTH-1] ^ a_msb));
`else
   digit_sub #(.W(DIGIT_W)) u_dig (
      .a(a_sr[DIGIT_W-1:0]), .b(b_sr[DIGIT_W-1:0]),
      .bi(brw), .d(dg), .bo(dg_bo));
   assign ovf_nx = (a_msb ^ b_msb) & (diff_nx[WIDTH-1] ^ a_msb);
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = BUSY;
         BUSY:    if (last)   state_nx = DONE;
         DONE:    if (take)   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         diff_r <= '0;
         brw    <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         bout_r <= 1'b0;
         ovf_r  <= 1'b0;
         zero_r <= 1'b0;
         ovld_r <= 1'b0;
`ifdef SUB32_ADD_MODE_EN
         add_r  <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (accept) begin
               a_sr  <= bus.a;
               b_sr  <= bus.b;
               brw   <= bus.bin;
               a_msb <= bus.a[WIDTH-1];
               b_msb <= bus.b[WIDTH-1];
               cnt   <= '0;
`ifdef SUB32_ADD_MODE_EN
               add_r <= bus.op_add;
`endif
            end
            BUSY: begin
               a_sr   <= a_sr >> DIGIT_W;
               b_sr   <= b_sr >> DIGIT_W;
               diff_r <= diff_nx;
               brw    <= dg_bo;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  bout_r <= dg_bo;
                  ovf_r  <= ovf_nx;
                  zero_r <= ~|diff_nx;
               end
            end
            // out_valid trails DONE entry by one edge so results are fully settled.
            DONE:    ovld_r <= !take;
            default: ovld_r <= 1'b0;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = ovld_r;
   assign bus.diff      = diff_r;
   assign bus.bout      = bout_r;
   assign bus.ovf       = ovf_r;
   assign bus.zero      = zero_r;
endmodule

// File: tb/tb_sub_32_bit_serial.sv
// Directed self-checking bench for sub_32_bit_serial.
module tb_sub_32_bit_serial;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   sub_32_bit_serial_if #(.WIDTH(32)) bus();
   sub_32_bit_serial #(.WIDTH(32), .DIGIT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // Present operands, wait for accept, then count edges until out_valid.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                        input logic add, output int lat, output logic rdy_seen);
      int g;
      bus.a = a; bus.b = b; bus.bin = bi;
`ifdef SUB32_ADD_MODE_EN
      bus.op_add = add;
`else
      if (add) $display("note: add mode not built");
`endif
      bus.in_valid = 1'b1;
      g = 0;
      while (!bus.in_ready && g < 20) begin @(posedge clk); #1; g++; end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0; rdy_seen = 1'b0;
      while (lat < 30) begin
         if (bus.in_ready) rdy_seen = 1'b1;
         @(posedge clk); #1;
         lat++;
         if (bus.out_valid) break;
      end
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; #1;
      n_cmp++; if (bus.in_ready  !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.diff !== 32'h0) begin n_bad++; $display("FAIL rst_diff got %h want 0", bus.diff); end
      n_cmp++; if ({bus.bout, bus.ovf, bus.zero} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b want 000", {bus.bout, bus.ovf, bus.zero}); end
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat; logic rs;
      bus.out_ready = 1'b1;  // asserted early: must not matter before out_valid
      do_op(32'h5, 32'h3, 1'b0, 1'b0, lat, rs);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL basic_latency got %0d want 9", lat); end
      n_cmp++; if (rs !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready_busy got %b want 0", rs); end
      n_cmp++; if (bus.diff !== 32'h2) begin n_bad++; $display("FAIL basic_diff got %h want 00000002", bus.diff); end
      n_cmp++; if ({bus.bout, bus.ovf, bus.zero} !== 3'b000) begin n_bad++; $display("FAIL basic_flags got %b want 000", {bus.bout, bus.ovf, bus.zero}); end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_release got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready); end
   endtask

   task automatic test_underflow();
      int lat; logic rs;
      do_op(32'h0, 32'h1, 1'b0, 1'b0, lat, rs);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL under_latency got %0d want 9", lat); end
      n_cmp++; if (bus.diff !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL under_diff got %h want ffffffff", bus.diff); end
      n_cmp++; if ({bus.bout, bus.ovf, bus.zero} !== 3'b100) begin n_bad++; $display("FAIL under_flags got %b want 100", {bus.bout, bus.ovf, bus.zero}); end
      consume();
   endtask

   task automatic test_overflow();
      int lat; logic rs;
      do_op(32'h80000000, 32'h1, 1'b0, 1'b0, lat, rs);
      n_cmp++; if (bus.diff !== 32'h7FFFFFFF) begin n_bad++; $display("FAIL ovf_diff got %h want 7fffffff", bus.diff); end
      n_cmp++; if ({bus.bout, bus.ovf, bus.zero} !== 3'b010) begin n_bad++; $display("FAIL ovf_flags got %b want 010", {bus.bout, bus.ovf, bus.zero}); end
      consume();
   endtask

   task automatic test_zero();
      int lat; logic rs;
      do_op(32'h12345678, 32'h12345677, 1'b1, 1'b0, lat, rs);
      n_cmp++; if (bus.diff !== 32'h0) begin n_bad++; $display("FAIL zero_diff got %h want 00000000", bus.diff); end
      n_cmp++; if ({bus.bout, bus.ovf, bus.zero} !== 3'b001) begin n_bad++; $display("FAIL zero_flags got %b want 001", {bus.bout, bus.ovf, bus.zero}); end
      consume();
   endtask

   task automatic test_backpressure();
      int lat; logic rs; logic bad;
      do_op(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0, lat, rs);
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = ~bus.in_valid;
         bus.a = $urandom;
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.diff !== 32'h4B4B4B4B ||
             {bus.bout, bus.ovf, bus.zero} !== 3'b010) bad = 1'b1;
      end
      bus.in_valid = 1'b0;
      n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL bp_hold got diff=%h v=%b r=%b want diff=4b4b4b4b v=1 r=0", bus.diff, bus.out_valid, bus.in_ready); end
      consume();
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_no_accept got r=%b want 1", bus.in_ready); end
   endtask

   task automatic test_reset_midbusy();
      int lat; logic rs;
      bus.a = 32'hFFFFFFFF; bus.b = 32'h0; bus.bin = 1'b0;
`ifdef SUB32_ADD_MODE_EN
      bus.op_add = 1'b0;
`endif
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_hs got r=%b v=%b want r=1 v=0", bus.in_ready, bus.out_valid); end
      n_cmp++; if (bus.diff !== 32'h0 || {bus.bout, bus.ovf, bus.zero} !== 3'b000) begin n_bad++; $display("FAIL mid_rst_out got diff=%h flags=%b want 0/000", bus.diff, {bus.bout, bus.ovf, bus.zero}); end
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(32'h10, 32'h20, 1'b0, 1'b0, lat, rs);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL post_rst_latency got %0d want 9", lat); end
      n_cmp++; if (bus.diff !== 32'hFFFFFFF0) begin n_bad++; $display("FAIL post_rst_diff got %h want fffffff0", bus.diff); end
      n_cmp++; if ({bus.bout, bus.ovf, bus.zero} !== 3'b100) begin n_bad++; $display("FAIL post_rst_flags got %b want 100", {bus.bout, bus.ovf, bus.zero}); end
      consume();
   endtask

`ifdef SUB32_ADD_MODE_EN
   task automatic test_add_mode();
      int lat; logic rs;
      do_op(32'h3EBF3EBF, 32'h55555555, 1'b0, 1'b1, lat, rs);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL add_latency got %0d want 9", lat); end
      n_cmp++; if (bus.diff !== 32'h94149414) begin n_bad++; $display("FAIL add_diff got %h want 94149414", bus.diff); end
      n_cmp++; if ({bus.bout, bus.ovf, bus.zero} !== 3'b010) begin n_bad++; $display("FAIL add_flags got %b want 010", {bus.bout, bus.ovf, bus.zero}); end
      consume();
      bus.op_add = 1'b0;
   endtask
`endif

   initial begin
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b0;
`ifdef SUB32_ADD_MODE_EN
      bus.op_add = 1'b0;
`endif
      test_reset();
      test_basic();
      test_underflow();
      test_overflow();
      test_zero();
      test_backpressure();
      test_reset_midbusy();
`ifdef SUB32_ADD_MODE_EN
      test_add_mode();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
